// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, one-word-per-line data cache controller.
// Loads that hit return in the same cycle; misses and stores go to main memory.
module dcache_ctrl #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES];
  logic [29:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    hit_q, miss_q;

  logic                hit_inc, miss_inc, line_we, hit;
  logic [31:0]         line_wdata;
  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                unused_addr_bits;

  assign req_idx          = cpu_addr[IDX_W+1:2];
  assign req_tag          = cpu_addr[31:IDX_W+2];
  assign fill_idx         = addr_q[IDX_W-1:0];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    line_we    = 1'b0;
    line_wdata = wdata_q;
    cpu_rdata  = 32'h0;
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        // flush wins; any pending request is simply seen again next cycle
        if (flush) begin
          cpu_stall = 1'b1;
          valid_d   = '0;
        end else if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            addr_d    = cpu_addr[31:2];
            wdata_d   = cpu_wdata;
            state_d   = WRITE;
          end else if (hit) begin
            cpu_rdata = data_q[req_idx];
            hit_inc   = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            addr_d    = cpu_addr[31:2];
            wdata_d   = cpu_wdata;
            miss_inc  = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q, 2'b00};
        if (mem_ack) begin
          line_we    = 1'b1;
          line_wdata = mem_rdata;
          cpu_rdata  = mem_rdata;
          valid_d[fill_idx] = 1'b1;
          state_d    = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) begin
          line_we    = 1'b1;
          line_wdata = wdata_q;
          valid_d[fill_idx] = 1'b1;
          state_d    = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (hit_inc && (hit_q != {CNT_W{1'b1}}))
        hit_q <= hit_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (miss_inc && (miss_q != {CNT_W{1'b1}}))
        miss_q <= miss_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tag and data need no reset: the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[fill_idx]  <= addr_q[29:IDX_W];
      data_q[fill_idx] <= line_wdata;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed table, flush/reset sequences,
// and randomized accesses scored against a line-level cache model.
module tb_dcache_ctrl;

  localparam int IDX  = 3;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk, rst;
  logic          cpu_req, cpu_we, flush, mem_ack;
  logic [31:0]   cpu_addr, cpu_wdata, mem_rdata;
  logic [31:0]   cpu_rdata, mem_addr, mem_wdata;
  logic          cpu_stall, mem_req, mem_we;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.IDX_W(IDX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: which word each line holds, its contents, and main memory.
  logic          m_valid [1<<IDX];
  logic [29:0]   m_line  [1<<IDX];
  logic [31:0]   m_data  [1<<IDX];
  logic [31:0]   mem_m   [logic [29:0]];
  int            m_hits, m_miss;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, mrd;
    int          lat;
    logic        exp_hit;
    logic [31:0] exp_rd;
    int          exp_hits, exp_miss;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem_m.exists(a[31:2])) mem_m[a[31:2]] = $urandom;
    return mem_m[a[31:2]];
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[IDX+1:2]);
    return m_valid[idx] && (m_line[idx] == a[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1<<IDX); i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  // One CPU access; memory answers 'lat' cycles after mem_req first appears.
  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] mrd, input int lat, input logic exp_hit,
                     input logic [31:0] exp_rd);
    int idx;
    idx = int'(addr[IDX+1:2]);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    flush = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    if (!we && exp_hit) begin
      chk("hit_stall", cpu_stall, 0);
      chk("hit_rdata", cpu_rdata, exp_rd);
      if (m_hits < MAXC) m_hits++;
    end else begin
      chk("req_stall", cpu_stall, 1);
      chk("req_memreq_idle", mem_req, 0);
      if (!we && m_miss < MAXC) m_miss++;
      @(posedge clk); #1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("wait_stall", cpu_stall, 1);
        chk("wait_memreq", mem_req, 1);
        chk("wait_memwe", mem_we, we);
        chk("wait_memaddr", mem_addr, {addr[31:2], 2'b00});
        if (we) chk("wait_memwdata", mem_wdata, wdata);
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = mrd;
      @(negedge clk);
      chk("ack_stall", cpu_stall, 0);
      chk("ack_memreq", mem_req, 1);
      if (!we) chk("ack_rdata", cpu_rdata, exp_rd);
      m_valid[idx] = 1'b1;
      m_line[idx]  = addr[31:2];
      m_data[idx]  = we ? wdata : mrd;
      mem_m[addr[31:2]] = m_data[idx];
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rand_acc();
    logic        we;
    logic [31:0] a, wd, rd;
    we = ($urandom_range(0, 9) < 3);
    a  = 32'($urandom_range(0, 63)) << 2;
    a[1:0] = 2'($urandom_range(0, 3));
    wd = $urandom;
    if (!we && model_hit(a)) rd = m_data[int'(a[IDX+1:2])];
    else rd = we ? $urandom : mem_read(a);
    acc(we, a, wd, rd, $urandom_range(0, 3), model_hit(a), rd);
    chk("rand_hit_cnt", hit_cnt, m_hits);
    chk("rand_miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    vt[0] = '{1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 0, 1};
    vt[1] = '{1'b0, 32'h40, 32'h0,        32'h0,        0, 1'b1, 32'hDEADBEEF, 1, 1};
    vt[2] = '{1'b0, 32'h60, 32'h0,        32'hCAFE0060, 1, 1'b0, 32'hCAFE0060, 1, 2};
    vt[3] = '{1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1, 3};
    vt[4] = '{1'b1, 32'h44, 32'h12345678, 32'hBADBAD00, 2, 1'b0, 32'h0,        1, 3};
    vt[5] = '{1'b0, 32'h44, 32'h0,        32'h0,        0, 1'b1, 32'h12345678, 2, 3};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memreq", mem_req, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_stall", cpu_stall, 0);
    @(posedge clk); #1 rst = 1'b0;

    // idle: no request, stray ack ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("idle_stall", cpu_stall, 0);
    chk("idle_rdata", cpu_rdata, 0);
    chk("idle_memreq", mem_req, 0);
    chk("idle_memwe", mem_we, 0);
    @(posedge clk); #1 mem_ack = 1'b0;

    for (int i = 0; i < 6; i++) begin
      acc(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].mrd, vt[i].lat, vt[i].exp_hit, vt[i].exp_rd);
      chk($sformatf("vec%0d_hit_cnt", i), hit_cnt, vt[i].exp_hits);
      chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, vt[i].exp_miss);
    end

    // flush with a hitting load pending: one stall, then the load misses
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", cpu_stall, 1);
    chk("flush_memreq", mem_req, 0);
    chk("flush_hit_cnt_hold", hit_cnt, 2);
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < (1<<IDX); i++) m_valid[i] = 1'b0;
    acc(1'b0, 32'h44, 32'h0, 32'h12345678, 1, 1'b0, 32'h12345678);
    chk("flush_miss_cnt", miss_cnt, 4);
    chk("flush_hit_cnt", hit_cnt, 2);

    for (int i = 0; i < 200; i++) rand_acc();

    // saturate the hit counter
    acc(1'b0, 32'h100, 32'h0, 32'hA5A5A5A5, 0, model_hit(32'h100),
        model_hit(32'h100) ? m_data[0] : 32'hA5A5A5A5);
    for (int i = 0; i < 70; i++) acc(1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'hA5A5A5A5);
    chk("sat_hit_cnt", hit_cnt, MAXC);

    // reset in the middle of a refill
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    @(negedge clk);
    chk("rstmid_req_stall", cpu_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_memreq_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_memreq", mem_req, 0);
    chk("rstmid_memwe", mem_we, 0);
    chk("rstmid_hit_cnt", hit_cnt, 0);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("late_ack_memreq", mem_req, 0);
    chk("late_ack_stall", cpu_stall, 0);
    @(posedge clk); #1 mem_ack = 1'b0;
    acc(1'b0, 32'h200, 32'h0, 32'h11112222, 1, 1'b0, 32'h11112222);
    acc(1'b0, 32'h100, 32'h0, 32'h33334444, 0, 1'b0, 32'h33334444);
    chk("post_rst_miss_cnt", miss_cnt, 2);
    chk("post_rst_hit_cnt", hit_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
